cfo_corrector_mc: RTL and testbench
===================================

Name: cfo_corrector_mc

Overview:
Multi-channel carrier-frequency-offset corrector for the PSS search front-end. It sits ahead of the decimating CIC and the PSS correlator. Time-interleaved samples carry a channel tag. Each channel has its own signed CFO word and phase accumulator, and each sample is rotated by exp(+j·2π·phase/2^PHASE_DW) using an internal sin/cos LUT and a rounding, saturating complex multiplier. Successor to the single-channel DDS+multiplier path: N channels, runtime CFO/phase-clear handshake, bypass mode, defined saturation.

Parameters:
IN_DW, 32, IQ sample width; real = [IN_DW/2-1:0], imag = [IN_DW-1:IN_DW/2], signed
NUM_CH, 4, number of interleaved channels (1..16)
PHASE_DW, 20, phase accumulator / CFO word width
LUT_AW, 10, quarter-wave LUT address width
SIN_DW, 16, sin/cos amplitude width; amplitude 2^(SIN_DW-1)-1
CH_W, max(1,$clog2(NUM_CH)), channel tag width (derived localparam)

Ports:
clk_i  in  1  clock
reset_i  in  1  synchronous, active-high reset
s_axis_in_tdata  in  IN_DW  input IQ sample
s_axis_in_tuser  in  CH_W  channel index of sample
s_axis_in_tvalid  in  1  sample valid (no backpressure)
cfo_valid_i  in  1  config write strobe
cfo_ch_i  in  CH_W  channel addressed by config write
cfo_i  in  PHASE_DW  signed CFO word = CFO_hz/fs·2^PHASE_DW (negate to correct)
cfo_phase_clr_i  in  1  with cfo_valid_i: also clear that channel's phase
bypass_i  in  1  1 = output equals delayed input
m_axis_out_tdata  out  IN_DW  corrected IQ sample, same packing
m_axis_out_tuser  out  CH_W  echoed channel index
m_axis_out_tvalid  out  1  output valid
sat_cnt_o  out  16  saturation event counter (see Optional Feature)

Behaviour:
- Reset: all outputs 0; all phase[ch] and cfo[ch] = 0; pipeline valids cleared. A reset mid-stream discards in-flight samples; no output valid in the cycle after reset.
- Fixed latency of 3 cycles, valid-to-valid. Order is preserved. Bubbles propagate unchanged.
- Cycle 0 (accept): the sample uses the current phase[ch]. Then phase[ch] <= phase[ch] + cfo[ch], modulo 2^PHASE_DW with natural wrap. The first sample per channel after reset or clear uses phase 0.
- Stage 1: the top LUT_AW+2 phase bits select quadrant and index. The LUT holds 2^LUT_AW+1 entries, round(A·sin(π/2·k/2^LUT_AW)) for k=0..2^LUT_AW, so values at 0/90/180/270 degrees are exact. cos and sin are registered.
- Stage 2: four signed products are registered at full width.
- Stage 3: re = xr·c − xi·s; im = xr·s + xi·c. Add 2^(SIN_DW-2), then arithmetic shift right by SIN_DW-1 (round half up). Saturate each component to [−2^(IN_DW/2-1), 2^(IN_DW/2-1)−1] and register.
- Config: a cfo_valid_i write takes effect immediately in the register.
  - If a write and a sample for the same channel arrive in the same cycle, the sample's increment uses the OLD cfo.
  - With cfo_phase_clr_i, phase[ch] <= 0. Clear beats increment; that same-cycle sample still uses its pre-clear phase.
- Channel tag ≥ NUM_CH: the sample is rotated with phase 0 and no state is updated. Its tag is echoed.
- bypass_i is sampled at accept and travels with the sample. A bypassed sample is output unchanged, with no rounding or saturation. Accumulators still advance, so leaving bypass is phase-continuous.
- No tready. The upstream stream must tolerate a continuous 1 sample/cycle.

Optional Feature:
CFO_CORRECTOR_SAT_CNT_EN: when defined, sat_cnt_o counts samples in which either component saturated in stage 3. The counter saturates at 0xFFFF and is cleared by reset. When not defined, sat_cnt_o is tied to 0 and no counter logic is built.

Decomposition:
- Package cfo_corrector_pkg: CH_W function, the LUT init function (computes the quarter-wave table), and the rounding/saturation function.
- One sub-module, cfo_sincos_lut: quarter-wave LUT plus quadrant folding, with a registered 1-cycle output of cos/sin.

Test Plan:
- NUM_CH=4, all cfo=0, input (1000,0) on ch0..3 every cycle → output (1000,0) with tags 0,1,2,3; latency exactly 3.
- cfo[1]=2^18 (quarter turn), 4 samples (1000,0) on ch1 → (1000,0),(0,1000),(−1000,0),(0,−1000). Ch0 remains unrotated.
- Phase at 45° (cfo=2^17, second sample), input (−32768,−32768) → imag saturates to −32768, real ≈ 0. sat_cnt_o=1 with the macro defined, 0 without.
- cfo write (ch2, 2^18, clr=1) in the same cycle as a ch2 sample → that sample uses the old phase. The next ch2 sample uses phase 0, the one after uses 90°.
- Toggle bypass_i mid-stream with cfo[0]=2^18 → bypassed samples equal input. The first non-bypassed sample continues the 90° progression.
- Assert reset_i with 3 samples in flight → no m_axis_out_tvalid after reset. Post-reset (1000,0) on ch1 returns (1000,0).

Source files
------------

// File: rtl/cfo_corrector_pkg.sv
// Shared helpers for the multi-channel CFO corrector: channel-tag width,
// quarter-wave sine table generator, and round-half-up / saturate helpers.
package cfo_corrector_pkg;

    // Channel tag width; a single-channel build still carries a 1-bit tag.
    function automatic int ch_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    // pi/2 in Q30, used by the table generator.
    localparam longint HALF_PI_Q30 = 64'sd1686629713;

    // Quarter-wave table entry k: round(A * sin(pi/2 * k / 2^aw)), A = 2^(dw-1)-1.
    // Integer Taylor series in Q30 so the table is an elaboration-time constant.
    function automatic int lut_value(input int k, input int aw, input int dw);
        longint x;
        longint term;
        longint acc;
        longint amp;
        x    = (longint'(k) * HALF_PI_Q30) >>> aw;
        term = x;
        acc  = x;
        for (int n = 1; n <= 12; n++) begin
            term = (term * x) >>> 30;
            term = (term * x) >>> 30;
            term = -term / longint'((2 * n) * (2 * n + 1));
            acc  = acc + term;
        end
        amp = (longint'(1) <<< (dw - 1)) - 1;
        return int'((acc * amp + (longint'(1) <<< 29)) >>> 30);
    endfunction

    // Add half an output LSB, then arithmetic shift (round half up).
    function automatic longint round_shift(input longint acc, input int sh);
        return (acc + (longint'(1) <<< (sh - 1))) >>> sh;
    endfunction

    // Rounded value clamped to a signed w-bit range.
    function automatic longint round_sat(input longint acc, input int sh, input int w);
        longint r;
        longint hi;
        longint lo;
        r  = round_shift(acc, sh);
        hi = (longint'(1) <<< (w - 1)) - 1;
        lo = -hi - 1;
        if (r > hi) return hi;
        if (r < lo) return lo;
        return r;
    endfunction

    // True when the rounded value does not fit a signed w-bit range.
    function automatic logic round_ovf(input longint acc, input int sh, input int w);
        longint r;
        longint hi;
        r  = round_shift(acc, sh);
        hi = (longint'(1) <<< (w - 1)) - 1;
        return (r > hi) || (r < (-hi - 1));
    endfunction

endpackage

// File: rtl/cfo_sincos_lut.sv
// Quarter-wave sin/cos lookup with quadrant folding. The table holds
// 2^LUT_AW+1 points so 0/90/180/270 degrees are exact. One-cycle registered output.
module cfo_sincos_lut
    import cfo_corrector_pkg::*;
#(
    parameter int LUT_AW = 10,
    parameter int SIN_DW = 16
) (
    input  logic                     clk_i,
    input  logic [LUT_AW+1:0]        phase_i,
    output logic signed [SIN_DW-1:0] cos_o,
    output logic signed [SIN_DW-1:0] sin_o
);

    localparam int N = 1 << LUT_AW;

    logic signed [SIN_DW-1:0] rom [0:N];

    for (genvar k = 0; k <= N; k++) begin : g_rom
        localparam logic signed [SIN_DW-1:0] V = SIN_DW'(lut_value(k, LUT_AW, SIN_DW));
        assign rom[k] = V;
    end

    logic [1:0]               quad;
    logic [LUT_AW:0]          idx;
    logic [LUT_AW:0]          idx_c;
    logic signed [SIN_DW-1:0] near;
    logic signed [SIN_DW-1:0] far;

    assign quad  = phase_i[LUT_AW+1:LUT_AW];
    assign idx   = {1'b0, phase_i[LUT_AW-1:0]};
    assign idx_c = (LUT_AW+1)'(N) - idx;
    assign near  = rom[idx];
    assign far   = rom[idx_c];

    // Fold the quarter-wave values into the full circle and register them.
    always_ff @(posedge clk_i) begin
        case (quad)
            2'd0: begin cos_o <= far;   sin_o <= near;  end
            2'd1: begin cos_o <= -near; sin_o <= far;   end
            2'd2: begin cos_o <= -far;  sin_o <= -near; end
            default: begin cos_o <= near; sin_o <= -far; end
        endcase
    end

endmodule

// File: rtl/cfo_corrector_mc.sv
// Multi-channel carrier-frequency-offset corrector. Per-channel phase
// accumulators drive a sin/cos LUT; each sample is rotated by a rounding,
// saturating complex multiply. Three-cycle fixed latency, no backpressure.
// Optional saturation counter: define CFO_CORRECTOR_SAT_CNT_EN.
module cfo_corrector_mc
    import cfo_corrector_pkg::*;
#(
    parameter int  IN_DW    = 32,
    parameter int  NUM_CH   = 4,
    parameter int  PHASE_DW = 20,
    parameter int  LUT_AW   = 10,
    parameter int  SIN_DW   = 16,
    localparam int CH_W     = ch_width(NUM_CH)
) (
    input  logic                       clk_i,
    input  logic                       reset_i,
    input  logic [IN_DW-1:0]           s_axis_in_tdata,
    input  logic [CH_W-1:0]            s_axis_in_tuser,
    input  logic                       s_axis_in_tvalid,
    input  logic                       cfo_valid_i,
    input  logic [CH_W-1:0]            cfo_ch_i,
    input  logic signed [PHASE_DW-1:0] cfo_i,
    input  logic                       cfo_phase_clr_i,
    input  logic                       bypass_i,
    output logic [IN_DW-1:0]           m_axis_out_tdata,
    output logic [CH_W-1:0]            m_axis_out_tuser,
    output logic                       m_axis_out_tvalid,
    output logic [15:0]                sat_cnt_o
);

    localparam int HALF  = IN_DW / 2;
    localparam int PW    = HALF + SIN_DW;
    localparam int NSLOT = 1 << CH_W;

    logic signed [PHASE_DW-1:0] phase_q [0:NSLOT-1];
    logic signed [PHASE_DW-1:0] cfo_q   [0:NSLOT-1];

    logic              ch_ok;
    logic              sample_ok;
    logic [LUT_AW+1:0] lut_phase;

    // Out-of-range tags rotate by phase 0 and leave all state untouched.
    assign ch_ok     = int'(s_axis_in_tuser) < NUM_CH;
    assign sample_ok = s_axis_in_tvalid & ch_ok;
    assign lut_phase = ch_ok ? phase_q[s_axis_in_tuser][PHASE_DW-1 -: LUT_AW+2] : '0;

    // Per-channel CFO words and phase accumulators; clear beats increment.
    always_ff @(posedge clk_i) begin
        for (int c = 0; c < NSLOT; c++) begin
            if (reset_i) begin
                phase_q[c] <= '0;
                cfo_q[c]   <= '0;
            end else begin
                if (cfo_valid_i && cfo_ch_i == CH_W'(c)) begin
                    cfo_q[c] <= cfo_i;
                end
                if (cfo_valid_i && cfo_phase_clr_i && cfo_ch_i == CH_W'(c)) begin
                    phase_q[c] <= '0;
                end else if (sample_ok && s_axis_in_tuser == CH_W'(c)) begin
                    phase_q[c] <= phase_q[c] + cfo_q[c];
                end
            end
        end
    end

    // ---- stage 1: LUT lookup, sample captured alongside ----
    logic signed [SIN_DW-1:0] cos_p0;
    logic signed [SIN_DW-1:0] sin_p0;
    logic [IN_DW-1:0]         x_p0;
    logic [CH_W-1:0]          tuser_p0;
    logic                     byp_p0;
    logic                     vld_p0;

    cfo_sincos_lut #(
        .LUT_AW (LUT_AW),
        .SIN_DW (SIN_DW)
    ) u_lut (
        .clk_i   (clk_i),
        .phase_i (lut_phase),
        .cos_o   (cos_p0),
        .sin_o   (sin_p0)
    );

    // Stage-1 data capture.
    always_ff @(posedge clk_i) begin
        x_p0     <= s_axis_in_tdata;
        tuser_p0 <= s_axis_in_tuser;
        byp_p0   <= bypass_i;
    end

    logic signed [HALF-1:0] xr_p0;
    logic signed [HALF-1:0] xi_p0;
    assign xr_p0 = x_p0[HALF-1:0];
    assign xi_p0 = x_p0[IN_DW-1:HALF];

    // ---- stage 2: full-width signed products ----
    logic signed [PW-1:0] prc_p1;
    logic signed [PW-1:0] pis_p1;
    logic signed [PW-1:0] prs_p1;
    logic signed [PW-1:0] pic_p1;
    logic [IN_DW-1:0]     x_p1;
    logic [CH_W-1:0]      tuser_p1;
    logic                 byp_p1;
    logic                 vld_p1;

    // Stage-2 products and sample pass-through for bypass.
    always_ff @(posedge clk_i) begin
        prc_p1   <= xr_p0 * cos_p0;
        pis_p1   <= xi_p0 * sin_p0;
        prs_p1   <= xr_p0 * sin_p0;
        pic_p1   <= xi_p0 * cos_p0;
        x_p1     <= x_p0;
        tuser_p1 <= tuser_p0;
        byp_p1   <= byp_p0;
    end

    // Valid pipeline; reset discards everything in flight.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            vld_p0 <= 1'b0;
            vld_p1 <= 1'b0;
        end else begin
            vld_p0 <= s_axis_in_tvalid;
            vld_p1 <= vld_p0;
        end
    end

    // ---- stage 3: sum, round half up, saturate ----
    logic signed [PW:0]     re_acc;
    logic signed [PW:0]     im_acc;
    logic signed [HALF-1:0] re_val;
    logic signed [HALF-1:0] im_val;

    assign re_acc = (PW+1)'(prc_p1) - (PW+1)'(pis_p1);
    assign im_acc = (PW+1)'(prs_p1) + (PW+1)'(pic_p1);
    assign re_val = HALF'(round_sat(longint'(re_acc), SIN_DW - 1, HALF));
    assign im_val = HALF'(round_sat(longint'(im_acc), SIN_DW - 1, HALF));

    // Output register; bypassed samples leave untouched.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            m_axis_out_tdata  <= '0;
            m_axis_out_tuser  <= '0;
            m_axis_out_tvalid <= 1'b0;
        end else begin
            m_axis_out_tdata  <= byp_p1 ? x_p1 : {im_val, re_val};
            m_axis_out_tuser  <= tuser_p1;
            m_axis_out_tvalid <= vld_p1;
        end
    end

`ifdef CFO_CORRECTOR_SAT_CNT_EN
    logic sat_evt;
    assign sat_evt = vld_p1 & ~byp_p1 &
                     (round_ovf(longint'(re_acc), SIN_DW - 1, HALF) |
                      round_ovf(longint'(im_acc), SIN_DW - 1, HALF));

    // Count saturating samples, sticking at all-ones.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            sat_cnt_o <= '0;
        end else if (sat_evt && sat_cnt_o != 16'hFFFF) begin
            sat_cnt_o <= sat_cnt_o + 16'd1;
        end
    end
`else
    assign sat_cnt_o = '0;
`endif

endmodule

// File: tb/tb_cfo_corrector_mc.sv
// Directed, table-driven bench for cfo_corrector_mc (NUM_CH=4, default widths).
module tb_cfo_corrector_mc;

    localparam int CH_W = 2;
    localparam int Q17  = 131072;
    localparam int Q18  = 262144;

    logic        clk_i = 1'b0;
    logic        reset_i;
    logic [31:0] s_axis_in_tdata;
    logic [1:0]  s_axis_in_tuser;
    logic        s_axis_in_tvalid;
    logic        cfo_valid_i;
    logic [1:0]  cfo_ch_i;
    logic [19:0] cfo_i;
    logic        cfo_phase_clr_i;
    logic        bypass_i;
    logic [31:0] m_axis_out_tdata;
    logic [1:0]  m_axis_out_tuser;
    logic        m_axis_out_tvalid;
    logic [15:0] sat_cnt_o;

    cfo_corrector_mc dut (
        .clk_i             (clk_i),
        .reset_i           (reset_i),
        .s_axis_in_tdata   (s_axis_in_tdata),
        .s_axis_in_tuser   (s_axis_in_tuser),
        .s_axis_in_tvalid  (s_axis_in_tvalid),
        .cfo_valid_i       (cfo_valid_i),
        .cfo_ch_i          (cfo_ch_i),
        .cfo_i             (cfo_i),
        .cfo_phase_clr_i   (cfo_phase_clr_i),
        .bypass_i          (bypass_i),
        .m_axis_out_tdata  (m_axis_out_tdata),
        .m_axis_out_tuser  (m_axis_out_tuser),
        .m_axis_out_tvalid (m_axis_out_tvalid),
        .sat_cnt_o         (sat_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    int cyc = 0;
    always @(posedge clk_i) cyc <= cyc + 1;

    typedef struct {
        bit v; int ch; int re; int im; bit byp; int ere; int eim;
        bit cv; int cch; int cfo; bit clr;
    } vec_t;

    typedef struct { int id; int due; int ch; int re; int im; } exp_t;

    vec_t vecs[$];
    exp_t q[$];
    exp_t e;
    int   total = 0;
    int   bad   = 0;
    int   exp_sat;

    task automatic check(input string nm, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s: got %0d, want %0d", nm, act, req);
        end
    endtask

    function automatic vec_t mk(input bit v, input int ch, input int re, input int im,
                                input bit byp, input int ere, input int eim,
                                input bit cv, input int cch, input int cfo, input bit clr);
        vec_t r;
        r.v = v; r.ch = ch; r.re = re; r.im = im; r.byp = byp; r.ere = ere; r.eim = eim;
        r.cv = cv; r.cch = cch; r.cfo = cfo; r.clr = clr;
        return r;
    endfunction

    // Apply one cycle of stimulus; queue the expected output when checked.
    task automatic drive(input vec_t t, input int id, input bit chk);
        @(negedge clk_i);
        s_axis_in_tvalid = t.v;
        s_axis_in_tuser  = CH_W'(t.ch);
        s_axis_in_tdata  = {16'(t.im), 16'(t.re)};
        bypass_i         = t.byp;
        cfo_valid_i      = t.cv;
        cfo_ch_i         = CH_W'(t.cch);
        cfo_i            = 20'(t.cfo);
        cfo_phase_clr_i  = t.clr;
        if (t.v && chk) q.push_back('{id: id, due: cyc + 3, ch: t.ch, re: t.ere, im: t.eim});
    endtask

    task automatic idle();
        drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), -1, 1'b0);
    endtask

    // Output monitor: order, latency, tag and data against the queue.
    always @(negedge clk_i) begin
        if (!reset_i) begin
            if (q.size() > 0 && cyc > q[0].due) begin
                check($sformatf("missing_out#%0d", q[0].id), cyc, q[0].due);
                void'(q.pop_front());
            end
            if (m_axis_out_tvalid) begin
                if (q.size() == 0) begin
                    check("unexpected_valid", 1, 0);
                end else begin
                    e = q.pop_front();
                    check($sformatf("latency#%0d", e.id), cyc, e.due);
                    check($sformatf("tuser#%0d", e.id), int'(m_axis_out_tuser), e.ch);
                    check($sformatf("re#%0d", e.id), int'($signed(m_axis_out_tdata[15:0])), e.re);
                    check($sformatf("im#%0d", e.id), int'($signed(m_axis_out_tdata[31:16])), e.im);
                end
            end
        end
    end

    initial begin
        reset_i = 1'b1;
        s_axis_in_tvalid = 1'b0; s_axis_in_tuser = '0; s_axis_in_tdata = '0;
        cfo_valid_i = 1'b0; cfo_ch_i = '0; cfo_i = '0; cfo_phase_clr_i = 1'b0; bypass_i = 1'b0;
`ifdef CFO_CORRECTOR_SAT_CNT_EN
        exp_sat = 1;
`else
        exp_sat = 0;
`endif

        // Vector table: one entry per cycle.
        for (int c = 0; c < 4; c++) vecs.push_back(mk(1, c, 1000, 0, 0, 1000, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(1, 0, 1000, 0, 0, 1000, 0, 1, 1, Q18, 0));
        vecs.push_back(mk(1, 1, 1000, 0, 0, 1000, 0, 0, 0, 0, 0));
        vecs.push_back(mk(1, 1, 1000, 0, 0, 0, 1000, 0, 0, 0, 0));
        vecs.push_back(mk(1, 0, 1000, 0, 0, 1000, 0, 0, 0, 0, 0));
        vecs.push_back(mk(1, 1, 1000, 0, 0, -1000, 0, 0, 0, 0, 0));
        vecs.push_back(mk(1, 1, 1000, 0, 0, 0, -1000, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 3, Q17, 0));
        vecs.push_back(mk(1, 3, 1000, 0, 0, 1000, 0, 0, 0, 0, 0));
        vecs.push_back(mk(1, 3, -32768, -32768, 0, 0, -32768, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 2, Q17, 0));
        vecs.push_back(mk(1, 2, 1000, 0, 0, 1000, 0, 0, 0, 0, 0));
        vecs.push_back(mk(1, 2, 1000, 0, 0, 707, 707, 1, 2, Q18, 1));
        vecs.push_back(mk(1, 2, 1000, 0, 0, 1000, 0, 0, 0, 0, 0));
        vecs.push_back(mk(1, 2, 1000, 0, 0, 0, 1000, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 0, Q18, 0));
        vecs.push_back(mk(1, 0, 1000, 0, 0, 1000, 0, 0, 0, 0, 0));
        vecs.push_back(mk(1, 0, 1234, -567, 1, 1234, -567, 0, 0, 0, 0));
        vecs.push_back(mk(1, 0, -32768, 32767, 1, -32768, 32767, 0, 0, 0, 0));
        vecs.push_back(mk(1, 0, 1000, 0, 0, 0, -1000, 0, 0, 0, 0));
        vecs.push_back(mk(1, 0, 0, 1000, 0, 0, 1000, 0, 0, 0, 0));
        vecs.push_back(mk(1, 1, 1000, 0, 0, 1000, 0, 0, 0, 0, 0));

        // Reset state.
        repeat (3) @(negedge clk_i);
        check("rst_tvalid", int'(m_axis_out_tvalid), 0);
        check("rst_tdata", int'(m_axis_out_tdata), 0);
        check("rst_tuser", int'(m_axis_out_tuser), 0);
        check("rst_sat_cnt", int'(sat_cnt_o), 0);
        reset_i = 1'b0;

        for (int i = 0; i < vecs.size(); i++) drive(vecs[i], i, 1'b1);
        for (int i = 0; i < 30 && q.size() > 0; i++) idle();
        check("drain_empty", q.size(), 0);
        check("sat_cnt", int'(sat_cnt_o), exp_sat);

        // Reset with samples in flight.
        drive(mk(1, 0, 500, 500, 0, 0, 0, 0, 0, 0, 0), -1, 1'b0);
        drive(mk(1, 1, 600, 600, 0, 0, 0, 0, 0, 0, 0), -1, 1'b0);
        @(negedge clk_i);
        s_axis_in_tvalid = 1'b1; s_axis_in_tuser = 2'd2; s_axis_in_tdata = {16'd700, 16'd700};
        reset_i = 1'b1;
        @(negedge clk_i);
        reset_i = 1'b0;
        s_axis_in_tvalid = 1'b0;
        check("post_rst_tvalid", int'(m_axis_out_tvalid), 0);
        check("post_rst_tdata", int'(m_axis_out_tdata), 0);
        check("post_rst_sat", int'(sat_cnt_o), 0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk_i);
            check($sformatf("flush_tvalid%0d", i), int'(m_axis_out_tvalid), 0);
        end
        drive(mk(1, 1, 1000, 0, 0, 1000, 0, 0, 0, 0, 0), 100, 1'b1);
        drive(mk(1, 1, 1000, 0, 0, 1000, 0, 0, 0, 0, 0), 101, 1'b1);
        for (int i = 0; i < 30 && q.size() > 0; i++) idle();
        check("drain_empty2", q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
